// File: rtl/nanov_peri_pkg.sv
// Shared constants and select encoding for the nanoV peripheral interconnect.
// Build option NANOV_PERI_TIMER_EN adds the timer at OFF_TIMER/OFF_TIMECMP.
package nanov_peri_pkg;

  localparam logic [31:0] OFF_GPIO     = 32'h0000_0000;
  localparam logic [31:0] OFF_GPIO_OUT = 32'h0000_0004;
  localparam logic [31:0] OFF_UART     = 32'h0000_0010;
  localparam logic [31:0] UART_STRIDE  = 32'h0000_0008;
  localparam logic [31:0] OFF_TIMER    = 32'h0000_0040;
  localparam logic [31:0] OFF_TIMECMP  = 32'h0000_0044;

  // STATUS sits one word above DATA inside each UART slot
  localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

  localparam int CH_W = 2;

  typedef enum logic [2:0] {
    SEL_NONE      = 3'd0,
    SEL_GPIO      = 3'd1,
    SEL_GPIO_OUT  = 3'd2,
    SEL_UART_DATA = 3'd3,
    SEL_UART_STAT = 3'd4,
    SEL_TIMER     = 3'd5,
    SEL_TIMECMP   = 3'd6
  } sel_kind_e;

  typedef struct packed {
    sel_kind_e       kind;
    logic [CH_W-1:0] ch;
  } sel_t;

  localparam sel_t SEL_RESET = '{kind: SEL_NONE, ch: '0};

  // CPU store data arrives LSB-first in bit 31
  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_peri_timer.sv
// Free-running 32-bit timer with a compare register and sticky match interrupt.
// Only instantiated when NANOV_PERI_TIMER_EN is defined.
module nanov_peri_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    count_d = count_q + 32'd1;
    cmp_d   = cmp_q;
    irq_d   = irq_q;
    if (wr_count) count_d = wr_data;
    if (count_q == cmp_q) irq_d = 1'b1;
    // A compare write on the match cycle wins, leaving the interrupt clear
    if (wr_cmp) begin
      cmp_d = wr_data;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign count = count_q;
  assign cmp   = cmp_q;
  assign irq   = irq_q;

endmodule

// File: rtl/nanov_peri_bus.sv
// Memory-mapped peripheral interconnect for nanoV: GPIO, UART steering, optional timer.
// Define NANOV_PERI_TIMER_EN to build the timer and timer_irq.
module nanov_peri_bus
  import nanov_peri_pkg::*;
#(
  parameter int          GPIO_W    = 8,
  parameter int          NUM_UART  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           data_out,
  input  logic                  store_addr_out,
  input  logic                  store_data_out,
  input  logic                  data_in_read,
  output logic [31:0]           ext_data_in,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic [NUM_UART-1:0]   uart_tx_en,
  output logic [7:0]            uart_tx_data,
  input  logic [NUM_UART-1:0]   uart_tx_busy,
  output logic [NUM_UART-1:0]   uart_rx_read,
  input  logic [NUM_UART-1:0]   uart_rx_valid,
  input  logic [8*NUM_UART-1:0] uart_rx_data,
  output logic                  timer_irq
);

  // Handshake: the CPU presents an address with store_addr_out, then data with
  // store_data_out (or consumes ext_data_in with data_in_read); no back-pressure.

  sel_t              sel_q, sel_d, dec_sel;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       wr_word;
  logic [7:0]        rx_byte;
  logic              rx_valid_sel;
  logic              tx_busy_sel;
  logic              unused_wr;

  assign wr_word   = rev32(data_out);
  assign unused_wr = ^wr_word;

`ifdef NANOV_PERI_TIMER_EN
  logic [31:0] tmr_count;
  logic [31:0] tmr_cmp;
  logic        tmr_irq;
  logic        tmr_wr_count;
  logic        tmr_wr_cmp;

  assign tmr_wr_count = store_data_out && (sel_q.kind == SEL_TIMER);
  assign tmr_wr_cmp   = store_data_out && (sel_q.kind == SEL_TIMECMP);

  nanov_peri_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_count (tmr_wr_count),
    .wr_cmp   (tmr_wr_cmp),
    .wr_data  (wr_word),
    .count    (tmr_count),
    .cmp      (tmr_cmp),
    .irq      (tmr_irq)
  );

  assign timer_irq = tmr_irq;
`else
  assign timer_irq = 1'b0;
`endif

  // Exact full-word match; anything else, including unbuilt channels, is SEL_NONE
  always_comb begin
    dec_sel = SEL_RESET;
    if (data_out == BASE_ADDR + OFF_GPIO)     dec_sel.kind = SEL_GPIO;
    if (data_out == BASE_ADDR + OFF_GPIO_OUT) dec_sel.kind = SEL_GPIO_OUT;
    for (int k = 0; k < NUM_UART; k++) begin
      if (data_out == BASE_ADDR + OFF_UART + UART_STRIDE * 32'(k)) begin
        dec_sel.kind = SEL_UART_DATA;
        dec_sel.ch   = CH_W'(k);
      end
      if (data_out == BASE_ADDR + OFF_UART + UART_STRIDE * 32'(k) + UART_STAT_OFS) begin
        dec_sel.kind = SEL_UART_STAT;
        dec_sel.ch   = CH_W'(k);
      end
    end
`ifdef NANOV_PERI_TIMER_EN
    if (data_out == BASE_ADDR + OFF_TIMER)   dec_sel.kind = SEL_TIMER;
    if (data_out == BASE_ADDR + OFF_TIMECMP) dec_sel.kind = SEL_TIMECMP;
`endif
  end

  always_comb begin
    sel_d      = store_addr_out ? dec_sel : sel_q;
    gpio_out_d = gpio_out_q;
    if (store_data_out && (sel_q.kind == SEL_GPIO)) gpio_out_d = wr_word[GPIO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= SEL_RESET;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      sel_q      <= sel_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  always_comb begin
    rx_byte      = '0;
    rx_valid_sel = 1'b0;
    tx_busy_sel  = 1'b0;
    for (int k = 0; k < NUM_UART; k++) begin
      if (sel_q.ch == CH_W'(k)) begin
        rx_byte      = uart_rx_data[8*k +: 8];
        rx_valid_sel = uart_rx_valid[k];
        tx_busy_sel  = uart_tx_busy[k];
      end
    end
  end

  // Strobes are forced low throughout reset
  always_comb begin
    uart_tx_en   = '0;
    uart_rx_read = '0;
    for (int k = 0; k < NUM_UART; k++) begin
      if (rst_n && (sel_q.kind == SEL_UART_DATA) && (sel_q.ch == CH_W'(k))) begin
        uart_tx_en[k]   = store_data_out;
        uart_rx_read[k] = data_in_read;
      end
    end
  end

  always_comb begin
    ext_data_in = '0;
    if (rst_n) begin
      case (sel_q.kind)
        SEL_GPIO:      ext_data_in[GPIO_W-1:0] = sync2_q;
        SEL_GPIO_OUT:  ext_data_in[GPIO_W-1:0] = gpio_out_q;
        SEL_UART_DATA: ext_data_in[7:0]        = rx_byte;
        SEL_UART_STAT: ext_data_in[1:0]        = {rx_valid_sel, tx_busy_sel};
`ifdef NANOV_PERI_TIMER_EN
        SEL_TIMER:     ext_data_in             = tmr_count;
        SEL_TIMECMP:   ext_data_in             = tmr_cmp;
`endif
        default:       ext_data_in             = '0;
      endcase
    end
  end

  assign gpio_out     = gpio_out_q;
  assign uart_tx_data = wr_word[7:0];

endmodule

// File: tb/tb_nanov_peri_bus.sv
// Self-checking bench for nanov_peri_bus (GPIO_W=8, NUM_UART=2); timer checks
// follow NANOV_PERI_TIMER_EN.
module tb_nanov_peri_bus;

  localparam int          GPIO_W   = 8;
  localparam int          NUM_UART = 2;
  localparam logic [31:0] BASE     = 32'h1000_0000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           data_out;
  logic                  store_addr_out;
  logic                  store_data_out;
  logic                  data_in_read;
  logic [31:0]           ext_data_in;
  logic [GPIO_W-1:0]     gpio_in;
  logic [GPIO_W-1:0]     gpio_out;
  logic [NUM_UART-1:0]   uart_tx_en;
  logic [7:0]            uart_tx_data;
  logic [NUM_UART-1:0]   uart_tx_busy;
  logic [NUM_UART-1:0]   uart_rx_read;
  logic [NUM_UART-1:0]   uart_rx_valid;
  logic [8*NUM_UART-1:0] uart_rx_data;
  logic                  timer_irq;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tmp;

  nanov_peri_bus #(
    .GPIO_W    (GPIO_W),
    .NUM_UART  (NUM_UART),
    .BASE_ADDR (BASE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_out       (data_out),
    .store_addr_out (store_addr_out),
    .store_data_out (store_data_out),
    .data_in_read   (data_in_read),
    .ext_data_in    (ext_data_in),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .uart_tx_en     (uart_tx_en),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_busy   (uart_tx_busy),
    .uart_rx_read   (uart_rx_read),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_data   (uart_rx_data),
    .timer_irq      (timer_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bit_rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = w[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic sb_expect(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%08h exp=<empty queue>", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #2;
    store_addr_out = 1'b0;
    store_data_out = 1'b0;
    data_in_read   = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    data_out       = a;
    store_addr_out = 1'b1;
    tick();
  endtask

  task automatic set_store(input logic [31:0] w);
    data_out       = bit_rev(w);
    store_data_out = 1'b1;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] w);
    set_addr(a);
    set_store(w);
    tick();
  endtask

  task automatic read_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sb_expect(exp);
    set_addr(a);
    #1;
    sb_compare(tag, ext_data_in);
  endtask

  initial begin
    rst_n = 1'b0; data_out = '0; store_addr_out = 1'b0; store_data_out = 1'b0;
    data_in_read = 1'b0; gpio_in = '0; uart_tx_busy = '0; uart_rx_valid = '0;
    uart_rx_data = '0;
    repeat (3) tick();
    store_data_out = 1'b1; data_in_read = 1'b1; #1;
    check("rst_hold_tx_en", 32'(uart_tx_en), 32'h0);
    check("rst_hold_ext", ext_data_in, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_ext_none", ext_data_in, 32'h0);

    // GPIO write and read-back
    write_reg(BASE, 32'h0000_00A5);
    check("gpio_wr", 32'(gpio_out), 32'hA5);
    read_reg("rd_gpio_out", BASE + 32'h4, 32'hA5);
    set_store(32'h0000_00FF); tick();
    check("gpio_out_ro", 32'(gpio_out), 32'hA5);

    // gpio_in synchroniser lag
    read_reg("rd_gpio_in0", BASE, 32'h0);
    gpio_in = 8'h3C;
    tick(); sb_expect(32'h0); #1; sb_compare("gpio_sync_lag", ext_data_in);
    tick(); sb_expect(32'h3C); #1; sb_compare("gpio_sync", ext_data_in);

    // Address and data strobe together: data goes to the old selection (GPIO)
    data_out = BASE + 32'h10; store_addr_out = 1'b1; store_data_out = 1'b1; #1;
    check("same_cyc_no_tx", 32'(uart_tx_en), 32'h0);
    tmp = bit_rev(BASE + 32'h10);
    tick();
    check("same_cyc_gpio", 32'(gpio_out), 32'(tmp[7:0]));
    set_store(32'h33); #1;
    check("same_cyc_new_sel_tx", 32'(uart_tx_en), 32'h1);
    check("same_cyc_tx_data", 32'(uart_tx_data), 32'h33);
    tick();

    // UART 1 transmit
    set_addr(BASE + 32'h18);
    set_store(32'h41); #1;
    check("uart1_tx_en", 32'(uart_tx_en), 32'h2);
    check("uart1_tx_data", 32'(uart_tx_data), 32'h41);
    tick(); #1;
    check("uart1_tx_en_drop", 32'(uart_tx_en), 32'h0);

    // UART receive
    uart_rx_data = 16'h5AC3;
    sb_expect(32'h5A); set_addr(BASE + 32'h18); data_in_read = 1'b1; #1;
    check("uart1_rx_read", 32'(uart_rx_read), 32'h2);
    sb_compare("uart1_rx_byte", ext_data_in);
    tick(); #1;
    check("uart1_rx_read_drop", 32'(uart_rx_read), 32'h0);
    sb_expect(32'hC3); set_addr(BASE + 32'h10); data_in_read = 1'b1; #1;
    check("uart0_rx_read", 32'(uart_rx_read), 32'h1);
    sb_compare("uart0_rx_byte", ext_data_in);
    tick();

    // UART status
    uart_rx_valid = 2'b11; uart_tx_busy = 2'b10;
    read_reg("uart1_stat", BASE + 32'h1C, 32'h3);
    read_reg("uart0_stat", BASE + 32'h14, 32'h2);

    // Unmapped / unbuilt channel
    read_reg("none_uart2", BASE + 32'h20, 32'h0);
    set_store(32'hFF); data_in_read = 1'b1; #1;
    check("none_tx_en", 32'(uart_tx_en), 32'h0);
    check("none_rx_read", 32'(uart_rx_read), 32'h0);
    tick();
    check("none_gpio_kept", 32'(gpio_out), 32'(tmp[7:0]));
    read_reg("none_gap", BASE + 32'h8, 32'h0);
    read_reg("none_high", 32'h2000_0000, 32'h0);

    // Reset while a UART channel is selected: strobes gated
    set_addr(BASE + 32'h18);
    rst_n = 1'b0; set_store(32'h55); data_in_read = 1'b1; #1;
    check("rst_mid_tx_en", 32'(uart_tx_en), 32'h0);
    check("rst_mid_rx_read", 32'(uart_rx_read), 32'h0);
    tick(); rst_n = 1'b1; tick();

    // Reset between GPIO address and data: store ignored afterwards
    set_addr(BASE);
    rst_n = 1'b0; #1;
    check("rst_mid_ext", ext_data_in, 32'h0);
    tick(); rst_n = 1'b1; tick();
    set_store(32'h77); #1;
    check("rst_abort_ext", ext_data_in, 32'h0);
    tick();
    check("rst_abort_gpio", 32'(gpio_out), 32'h0);
    write_reg(BASE, 32'h5A);
    check("gpio_after_rst", 32'(gpio_out), 32'h5A);

`ifdef NANOV_PERI_TIMER_EN
    read_reg("cmp_rst", BASE + 32'h44, 32'hFFFF_FFFF);
    set_store(32'd10); tick();
    set_addr(BASE + 32'h40);
    set_store(32'd5); tick(); #1;
    check("tmr_load", ext_data_in, 32'd5);
    for (int i = 1; i <= 6; i++) begin
      tick(); #1;
      check("tmr_irq_rise", 32'(timer_irq), 32'(i == 6));
    end
    check("tmr_count", ext_data_in, 32'd11);
    set_addr(BASE + 32'h44);
    check("tmr_irq_hold", 32'(timer_irq), 32'h1);
    set_store(32'd10); tick();
    check("tmr_irq_clear", 32'(timer_irq), 32'h0);
    // count=0 after this load; compare write lands exactly on count==10
    set_addr(BASE + 32'h40);
    set_store(32'd0); tick();
    set_addr(BASE + 32'h44);
    repeat (9) tick();
    set_store(32'd10); tick();
    check("tmr_match_wr_wins", 32'(timer_irq), 32'h0);
    tick();
    check("tmr_match_wr_after", 32'(timer_irq), 32'h0);
    set_addr(BASE + 32'h40);
    set_store(32'hFFFF_FFFF); tick(); #1;
    check("tmr_wrap_max", ext_data_in, 32'hFFFF_FFFF);
    tick(); #1;
    check("tmr_wrap_zero", ext_data_in, 32'h0);
    tick(); #1;
    check("tmr_wrap_one", ext_data_in, 32'h1);
`else
    read_reg("no_tmr_rd", BASE + 32'h40, 32'h0);
    set_store(32'h1234); tick();
    read_reg("no_tmr_rd_after_wr", BASE + 32'h40, 32'h0);
    read_reg("no_tmrcmp_rd", BASE + 32'h44, 32'h0);
    repeat (3) tick();
    check("no_tmr_irq", 32'(timer_irq), 32'h0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
